// File: rtl/branch_pkg.sv
// branch_pkg
//   Shared constants for branch prediction and recovery.
//   PRED_T / PRED_NT : encoding of a 1-bit prediction (0 = taken, 1 = not taken).
//   br_state_e       : recovery controller states.
//   is_mispredict    : compares a stored prediction against the resolved outcome.
package branch_pkg;

  localparam logic PRED_T  = 1'b0;
  localparam logic PRED_NT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_RECOVER = 2'd2
  } br_state_e;

  // A prediction of PRED_T is wrong exactly when the branch was not taken, and vice versa.
  function automatic logic is_mispredict(input logic pred, input logic taken);
    return (pred == PRED_T) != taken;
  endfunction

endpackage

// File: rtl/branch_pend_fifo.sv
// branch_pend_fifo
//   FIFO of unresolved branches, DEPTH entries of W bits each.
//   Ports:
//     Clk, Reset       : clock (rising edge), synchronous active-high reset
//     push, wdata      : write an entry (accepted when not full, or when popping the same cycle)
//     pop, rdata       : drop the head entry; rdata always shows the current head
//     flush_all        : discard every entry (wins over push and pop)
//     full, empty      : occupancy flags from the registered count
//     count            : number of valid entries
module branch_pend_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush_all,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // Head must be visible in the resolve cycle, so the read is combinational.
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !flush_all && (!full || pop);
    pop_ok   = pop && !empty && !flush_all;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_all) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Tracks branch predictions from ID until they resolve in EX, flushes and
//   redirects fetch on a mispredict, and strobes predictor training.
//   Inputs : Clk, Reset (sync, active-high), BrID/PredID/TargetID/FallThruID (push from ID),
//            BrEX/BranchEX (resolve oldest branch in EX).
//   Outputs: Flush, RedirectValid, RedirectPC (recovery), StallFetch (queue full),
//            UpdateEn, UpdateTaken (training), MispredCnt (saturating), ProtoErr (sticky).
//   All outputs are registered: they reflect the resolve one cycle after the BrEX edge.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNTW         = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            BrID,
  input  logic            PredID,
  input  logic [AW-1:0]   TargetID,
  input  logic [AW-1:0]   FallThruID,
  input  logic            BrEX,
  input  logic            BranchEX,
  output logic            Flush,
  output logic            RedirectValid,
  output logic [AW-1:0]   RedirectPC,
  output logic            StallFetch,
  output logic            UpdateEn,
  output logic            UpdateTaken,
  output logic [CNTW-1:0] MispredCnt,
  output logic            ProtoErr
);

  localparam int EW  = 1 + 2*AW;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e       state_q, state_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic            flush_q, flush_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [AW-1:0]   redirect_pc_q, redirect_pc_d;
  logic            stall_q, stall_d;
  logic            update_en_q, update_en_d;
  logic            update_taken_q, update_taken_d;
  logic [CNTW-1:0] mispred_cnt_q, mispred_cnt_d;
  logic            proto_err_q, proto_err_d;

  logic            do_push, do_pop, flush_all;
  logic            resolve, mispred;
  logic [CW-1:0]   cnt_after;
  logic [EW-1:0]   head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  logic            head_pred;
  logic [AW-1:0]   head_target, head_fallthru;
  assign {head_pred, head_target, head_fallthru} = head;

  branch_pend_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (do_push),
    .pop       (do_pop),
    .flush_all (flush_all),
    .wdata     ({PredID, TargetID, FallThruID}),
    .rdata     (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    update_en_d      = 1'b0;
    update_taken_d   = 1'b0;
    mispred_cnt_d    = mispred_cnt_q;
    proto_err_d      = proto_err_q;
    do_push          = 1'b0;
    do_pop           = 1'b0;
    flush_all        = 1'b0;
    resolve          = 1'b0;
    mispred          = 1'b0;

    case (state_q)
      ST_RECOVER: begin
        // The redirect cycle already showed Flush; hold it for the remaining cycles.
        // ID/EX traffic is wrong-path here and is ignored entirely.
        if (flush_cnt_q != '0) begin
          flush_d     = 1'b1;
          flush_cnt_d = flush_cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        resolve = BrEX && !fifo_empty;
        mispred = resolve && is_mispredict(head_pred, BranchEX);
        if (BrEX && fifo_empty)           proto_err_d = 1'b1;
        if (BrID && fifo_full && !BrEX)   proto_err_d = 1'b1;
        do_pop  = resolve;
        // A push alongside a mispredicting resolve is on the wrong path.
        do_push = BrID && !mispred && (!fifo_full || resolve);
        if (resolve) begin
          update_en_d    = 1'b1;
          update_taken_d = BranchEX;
        end
        if (mispred) begin
          flush_all        = 1'b1;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = BranchEX ? head_target : head_fallthru;
          if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + 1'b1;
          state_d          = ST_RECOVER;
          flush_cnt_d      = FCW'(FLUSH_CYCLES - 1);
        end
      end
    endcase

    // Occupancy after this cycle's push/pop/flush, used for state and StallFetch.
    cnt_after = fifo_count;
    if (do_push) cnt_after = cnt_after + 1'b1;
    if (do_pop)  cnt_after = cnt_after - 1'b1;
    if (flush_all) cnt_after = '0;

    if (state_q != ST_RECOVER && !mispred) begin
      state_d = (cnt_after != '0) ? ST_TRACK : ST_IDLE;
    end
    stall_d = (cnt_after == CW'(DEPTH));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q          <= ST_IDLE;
      flush_cnt_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stall_q          <= 1'b0;
      update_en_q      <= 1'b0;
      update_taken_q   <= 1'b0;
      mispred_cnt_q    <= '0;
      proto_err_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      stall_q          <= stall_d;
      update_en_q      <= update_en_d;
      update_taken_q   <= update_taken_d;
      mispred_cnt_q    <= mispred_cnt_d;
      proto_err_q      <= proto_err_d;
    end
  end

  assign Flush         = flush_q;
  assign RedirectValid = redirect_valid_q;
  assign RedirectPC    = redirect_pc_q;
  assign StallFetch    = stall_q;
  assign UpdateEn      = update_en_q;
  assign UpdateTaken   = update_taken_q;
  assign MispredCnt    = mispred_cnt_q;
  assign ProtoErr      = proto_err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl
//   Directed and random stimulus for branch_resolve_ctrl. Each driven cycle pushes the
//   expected registered outputs into a scoreboard queue; they are popped and compared
//   one cycle later.
module tb_branch_resolve_ctrl;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int FLUSH = 2;
  localparam int CNTW  = 4;

  logic            Clk;
  logic            Reset;
  logic            BrID, PredID, BrEX, BranchEX;
  logic [AW-1:0]   TargetID, FallThruID;
  logic            Flush, RedirectValid, StallFetch, UpdateEn, UpdateTaken, ProtoErr;
  logic [AW-1:0]   RedirectPC;
  logic [CNTW-1:0] MispredCnt;

  branch_resolve_ctrl #(
    .AW           (AW),
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH),
    .CNTW         (CNTW)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .BrID          (BrID),
    .PredID        (PredID),
    .TargetID      (TargetID),
    .FallThruID    (FallThruID),
    .BrEX          (BrEX),
    .BranchEX      (BranchEX),
    .Flush         (Flush),
    .RedirectValid (RedirectValid),
    .RedirectPC    (RedirectPC),
    .StallFetch    (StallFetch),
    .UpdateEn      (UpdateEn),
    .UpdateTaken   (UpdateTaken),
    .MispredCnt    (MispredCnt),
    .ProtoErr      (ProtoErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic            flush;
    logic            rv;
    logic [AW-1:0]   rpc;
    logic            stall;
    logic            upd;
    logic            updt;
    logic [CNTW-1:0] cnt;
    logic            perr;
  } exp_t;

  typedef struct {
    logic          pred;
    logic [AW-1:0] tgt;
    logic [AW-1:0] ft;
  } ent_t;

  exp_t sb[$];
  ent_t mq[$];
  exp_t m_out;
  int   m_state;      // 0 idle/track, 2 recover
  int   m_flush_left;
  int   vectors;
  int   miscompares;

  // Reference behaviour for one clock, producing the outputs expected after the edge.
  task automatic model(input logic rst, input logic brid, input logic pred,
                       input logic [AW-1:0] tgt, input logic [AW-1:0] ft,
                       input logic brex, input logic taken);
    ent_t e;
    logic mis;
    mis         = 1'b0;
    m_out.flush = 1'b0;
    m_out.rv    = 1'b0;
    m_out.upd   = 1'b0;
    m_out.updt  = 1'b0;
    if (rst) begin
      mq.delete();
      m_state      = 0;
      m_flush_left = 0;
      m_out        = '0;
    end else if (m_state == 2) begin
      if (m_flush_left > 0) begin
        m_out.flush = 1'b1;
        m_flush_left--;
      end else begin
        m_state = 0;
      end
    end else begin
      if (brex) begin
        if (mq.size() == 0) begin
          m_out.perr = 1'b1;
        end else begin
          e          = mq.pop_front();
          m_out.upd  = 1'b1;
          m_out.updt = taken;
          mis        = ((e.pred == 1'b0) != taken);
          if (mis) begin
            m_out.rv    = 1'b1;
            m_out.rpc   = taken ? e.tgt : e.ft;
            m_out.flush = 1'b1;
            if (m_out.cnt != 4'hF) m_out.cnt = m_out.cnt + 1'b1;
            mq.delete();
            m_state      = 2;
            m_flush_left = FLUSH - 1;
          end
        end
      end
      if (brid && !mis) begin
        if (mq.size() < DEPTH) mq.push_back('{pred, tgt, ft});
        else                   m_out.perr = 1'b1;
      end
    end
    m_out.stall = (mq.size() == DEPTH);
  endtask

  task automatic step(input string tag, input logic rst, input logic brid, input logic pred,
                      input logic [AW-1:0] tgt, input logic [AW-1:0] ft,
                      input logic brex, input logic taken);
    exp_t got, expv;
    @(negedge Clk);
    Reset      = rst;
    BrID       = brid;
    PredID     = pred;
    TargetID   = tgt;
    FallThruID = ft;
    BrEX       = brex;
    BranchEX   = taken;
    model(rst, brid, pred, tgt, ft, brex, taken);
    sb.push_back(m_out);
    @(posedge Clk);
    #1;
    got  = '{Flush, RedirectValid, RedirectPC, StallFetch, UpdateEn, UpdateTaken, MispredCnt, ProtoErr};
    expv = sb.pop_front();
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h (fl rv rpc st ue ut cnt pe)", tag, got, expv);
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input string tag, input logic pred, input logic [AW-1:0] tgt,
                      input logic [AW-1:0] ft);
    step(tag, 1'b0, 1'b1, pred, tgt, ft, 1'b0, 1'b0);
  endtask

  task automatic resolve(input string tag, input logic taken);
    step(tag, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, taken);
  endtask

  // Independent spot check against a hand-derived constant.
  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    m_out        = '0;
    m_state      = 0;
    m_flush_left = 0;
    Reset = 1'b1; BrID = 1'b0; PredID = 1'b0; BrEX = 1'b0; BranchEX = 1'b0;
    TargetID = '0; FallThruID = '0;

    // 1: reset, correct not-taken prediction
    step("reset0", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    step("reset1", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("reset_cnt", 32'(MispredCnt), 32'h0);
    push("t1_push", 1'b1, 32'h200, 32'h14);
    resolve("t1_res", 1'b0);
    chk("t1_upd", 32'(UpdateEn), 32'h1);
    chk("t1_flush", 32'(Flush), 32'h0);
    idle("t1_idle");

    // 2: taken prediction, not taken outcome -> redirect to fall-through
    push("t2_push", 1'b0, 32'h100, 32'h44);
    resolve("t2_res", 1'b0);
    chk("t2_rpc", RedirectPC, 32'h44);
    chk("t2_cnt", 32'(MispredCnt), 32'h1);
    idle("t2_rec2");
    chk("t2_flush2", 32'(Flush), 32'h1);
    idle("t2_idle");
    chk("t2_flush_off", 32'(Flush), 32'h0);

    // 3: fill, overflow push, full pop+push, drain
    for (int i = 0; i < DEPTH; i++) push("t3_fill", 1'b1, 32'h1000 + i, 32'h2000 + i);
    chk("t3_stall", 32'(StallFetch), 32'h1);
    push("t3_over", 1'b1, 32'h3000, 32'h3004);
    chk("t3_perr", 32'(ProtoErr), 32'h1);
    step("t3_full_pp", 1'b0, 1'b1, 1'b1, 32'h4000, 32'h4004, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) resolve("t3_drain", 1'b0);
    chk("t3_unstall", 32'(StallFetch), 32'h0);
    idle("t3_idle");

    // 4: queue of 2, push alongside a mispredict -> all discarded, redirect from oldest
    push("t4_push_a", 1'b0, 32'h300, 32'h30);
    push("t4_push_b", 1'b1, 32'h400, 32'h40);
    step("t4_pp_mis", 1'b0, 1'b1, 1'b1, 32'h600, 32'h60, 1'b1, 1'b0);
    chk("t4_rpc", RedirectPC, 32'h30);
    idle("t4_rec2");
    idle("t4_rec_end");
    push("t4_push_c", 1'b1, 32'h500, 32'h54);
    resolve("t4_res_c", 1'b1);
    chk("t4_rpc_c", RedirectPC, 32'h500);
    idle("t4_rec2b");
    idle("t4_idle");

    // 5: reset in the first recover cycle
    push("t5_push", 1'b0, 32'h700, 32'h74);
    resolve("t5_mis", 1'b0);
    step("t5_reset", 1'b1, 1'b1, 1'b0, 32'h800, 32'h84, 1'b1, 1'b1);
    chk("t5_rpc0", RedirectPC, 32'h0);
    idle("t5_after");
    chk("t5_flush0", 32'(Flush), 32'h0);

    // 6: resolve on empty queue, then counter saturation
    resolve("t6_empty", 1'b1);
    chk("t6_perr", 32'(ProtoErr), 32'h1);
    chk("t6_noupd", 32'(UpdateEn), 32'h0);
    for (int i = 0; i < 16; i++) begin
      push("t6_push", 1'b0, 32'h9000 + i, 32'hA000 + i);
      resolve("t6_mis", 1'b0);
      idle("t6_rec2");
      idle("t6_rec_end");
    end
    chk("t6_sat", 32'(MispredCnt), 32'hF);

    // Random traffic, including protocol violations
    step("rnd_reset", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      step("rnd", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
